// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes,
// datapath mux selects and the bundled control-strobe struct.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle; master is the controller side.
interface multicycle_controller_if #(
  parameter int OPCODE_W = 6,
  parameter int CNT_W    = 16
);
  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                mem_ready;
  logic                pc_write;
  logic                pc_write_cond;
  logic                i_or_d;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                mem_to_reg;
  logic                reg_dst;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic [1:0]          pc_src;
  logic [3:0]          state;
  logic                illegal_op;
  logic                instr_done;
  logic [CNT_W-1:0]    instr_count;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, state, illegal_op, instr_done, instr_count
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, state, illegal_op, instr_done, instr_count
  );
endinterface

// File: rtl/ctrl_decode.sv
// Moore output decode: state (plus mem_ready for the FETCH load strobes)
// to datapath control strobes.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_e i_state,
  input  logic   i_mem_ready,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_4;
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.pc_src    = PC_ALU;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: o_ctrl.alu_src_b = SRCB_SHIMM;
      S_MEMADR, S_ADDIEX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_op        = ALU_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_src        = PC_ALUOUT;
      end
      S_ADDIWB: o_ctrl.reg_write = 1'b1;
      S_JUMP: begin
        o_ctrl.pc_write = 1'b1;
        o_ctrl.pc_src   = PC_JUMP;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM with memory-ready stalls, illegal-opcode
// flag and retired-instruction counter.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int CNT_W       = 16,
  parameter int MEM_WAIT_EN = 1
) (
  input logic                     clk,
  input logic                     rst_n,
  multicycle_controller_if.master bus
);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             r_ill;
  logic             w_ready;
  logic [5:0]       w_op;
  logic             w_is_load;
  logic             w_retire;
  ctrl_t            w_ctrl;

  assign w_ready   = (MEM_WAIT_EN != 0) ? bus.mem_ready : 1'b1;
  assign w_op      = 6'(bus.opcode);
  assign w_is_load = (w_op == OP_LW) || (w_op == OP_LH) || (w_op == OP_LHU);

  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: w_retire = 1'b1;
      S_MEMWR: w_retire = w_ready;
      default: w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_ill   <= 1'b0;
    end else begin
      r_done <= w_retire;
      r_ill  <= 1'b0;
      if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
      case (r_state)
        S_FETCH:  if (w_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (w_op)
            OP_RTYPE:             r_state <= S_EXEC;
            OP_LW, OP_LH, OP_LHU: r_state <= S_MEMADR;
            OP_SW:                r_state <= S_MEMADR;
            OP_BEQ:               r_state <= S_BRANCH;
            OP_ADDI:              r_state <= S_ADDIEX;
            OP_J:                 r_state <= S_JUMP;
            default: begin
              r_state <= S_FETCH;
              r_ill   <= 1'b1;
            end
          endcase
        end
        // Opcode is still valid here: the IR only loads in FETCH.
        S_MEMADR: r_state <= w_is_load ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (w_ready) r_state <= S_MEMWB;
        S_MEMWR:  if (w_ready) r_state <= S_FETCH;
        S_EXEC:   r_state <= S_ALUWB;
        S_ADDIEX: r_state <= S_ADDIWB;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  ctrl_decode u_decode (
    .i_state     (r_state),
    .i_mem_ready (w_ready),
    .o_ctrl      (w_ctrl)
  );

  // Write strobes are held off while reset is asserted, even mid-instruction.
  assign bus.pc_write      = w_ctrl.pc_write & rst_n;
  assign bus.pc_write_cond = w_ctrl.pc_write_cond & rst_n;
  assign bus.mem_write     = w_ctrl.mem_write & rst_n;
  assign bus.ir_write      = w_ctrl.ir_write & rst_n;
  assign bus.reg_write     = w_ctrl.reg_write & rst_n;
  assign bus.i_or_d        = w_ctrl.i_or_d;
  assign bus.mem_read      = w_ctrl.mem_read;
  assign bus.mem_to_reg    = w_ctrl.mem_to_reg;
  assign bus.reg_dst       = w_ctrl.reg_dst;
  assign bus.alu_src_a     = w_ctrl.alu_src_a;
  assign bus.alu_src_b     = w_ctrl.alu_src_b;
  assign bus.alu_op        = w_ctrl.alu_op;
  assign bus.pc_src        = w_ctrl.pc_src;
  assign bus.state         = r_state;
  assign bus.illegal_op    = r_ill;
  assign bus.instr_done    = r_done;
  assign bus.instr_count   = r_cnt;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: per-instruction state schedules drive a reference model
// that is compared against two controllers (16-bit and 4-bit counters).
module tb_multicycle_controller;
  import ctrl_pkg::*;

  logic       clk, rst_n, zero, mem_ready;
  logic [5:0] opcode;
  int n_cmp = 0, n_err = 0;
  bit chk_en = 0;

  multicycle_controller_if #(.OPCODE_W(6), .CNT_W(16)) if16 ();
  multicycle_controller_if #(.OPCODE_W(6), .CNT_W(4))  if4 ();

  assign if16.opcode = opcode;  assign if4.opcode = opcode;
  assign if16.zero = zero;      assign if4.zero = zero;
  assign if16.mem_ready = mem_ready; assign if4.mem_ready = mem_ready;

  multicycle_controller #(.OPCODE_W(6), .CNT_W(16), .MEM_WAIT_EN(1)) u16 (
    .clk(clk), .rst_n(rst_n), .bus(if16.master));
  multicycle_controller #(.OPCODE_W(6), .CNT_W(4), .MEM_WAIT_EN(1)) u4 (
    .clk(clk), .rst_n(rst_n), .bus(if4.master));

  initial clk = 0;
  always #5 clk = ~clk;

  // ---- model: instruction class -> fixed state schedule ----
  // kinds: 0 rtype, 1 load, 2 store, 3 beq, 4 addi, 5 j, 6 illegal
  function automatic int kind_of(logic [5:0] op);
    case (op)
      6'b000000: return 0;
      6'b100011, 6'b100001, 6'b100101: return 1;
      6'b101011: return 2;
      6'b000100: return 3;
      6'b001000: return 4;
      6'b000010: return 5;
      default:   return 6;
    endcase
  endfunction

  function automatic int seq_len(int k);
    case (k)
      0: return 4; 1: return 5; 2: return 4; 3: return 3;
      4: return 4; 5: return 3; default: return 2;
    endcase
  endfunction

  function automatic int seq_state(int k, int p);
    if (p == 0) return 0;
    if (p == 1) return 1;
    case (k)
      0: return (p == 2) ? 6 : 7;
      1: return (p == 2) ? 2 : ((p == 3) ? 3 : 4);
      2: return (p == 2) ? 2 : 5;
      3: return 8;
      4: return (p == 2) ? 9 : 10;
      5: return 11;
      default: return 0;
    endcase
  endfunction

  // {pc_write,pc_write_cond,i_or_d,mem_read,mem_write,ir_write,mem_to_reg,
  //  reg_dst,reg_write,alu_src_a,alu_src_b,alu_op,pc_src}
  function automatic logic [15:0] exp_ctrl(int st, logic mr, logic rn);
    logic pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, sa;
    logic [1:0] sb, ao, ps;
    {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, sa} = 10'b0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (st)
      0: begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
      1: sb = 2'b11;
      2: begin sa = 1; sb = 2'b10; end
      3: begin mrd = 1; iod = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mwr = 1; iod = 1; end
      6: begin sa = 1; ao = 2'b10; end
      7: begin rw = 1; rdst = 1; end
      8: begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
      9: begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin pw = 1; ps = 2'b10; end
      default: ;
    endcase
    if (!rn) {pw, pwc, mwr, irw, rw} = 5'b0;
    return {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, sa, sb, ao, ps};
  endfunction

  int m_pos = 0, m_kind = 0, m_cnt = 0;
  bit m_done = 0, m_ill = 0;

  always @(posedge clk) begin
    int cur;
    bit stall;
    if (!rst_n) begin
      m_pos = 0; m_done = 0; m_ill = 0; m_cnt = 0;
    end else begin
      cur = seq_state(m_kind, m_pos);
      stall = (cur == 0 || cur == 3 || cur == 5) && !mem_ready;
      m_done = 0; m_ill = 0;
      if (m_pos == 1) begin
        m_kind = kind_of(opcode);
        if (m_kind == 6) begin m_ill = 1; m_pos = 0; end
        else m_pos = 2;
      end else if (!stall) begin
        if (m_pos >= 2 && m_pos == seq_len(m_kind) - 1) begin
          m_pos = 0; m_done = 1; m_cnt++;
        end else m_pos++;
      end
    end
  end

  // ---- mem_ready stall injection, steered by the model's state ----
  int fst = 0, mst = 0;
  always @(posedge clk) begin
    int st;
    #1;
    st = seq_state(m_kind, m_pos);
    if (st == 0 && fst > 0) begin mem_ready = 0; fst--; end
    else if ((st == 3 || st == 5) && mst > 0) begin mem_ready = 0; mst--; end
    else mem_ready = 1;
  end

  // ---- per-cycle compare ----
  always @(negedge clk) begin
    logic [15:0] e, a16, a4;
    int st;
    if (chk_en) begin
      st = seq_state(m_kind, m_pos);
      e = exp_ctrl(st, mem_ready, rst_n);
      a16 = {if16.pc_write, if16.pc_write_cond, if16.i_or_d, if16.mem_read,
             if16.mem_write, if16.ir_write, if16.mem_to_reg, if16.reg_dst,
             if16.reg_write, if16.alu_src_a, if16.alu_src_b, if16.alu_op, if16.pc_src};
      a4  = {if4.pc_write, if4.pc_write_cond, if4.i_or_d, if4.mem_read,
             if4.mem_write, if4.ir_write, if4.mem_to_reg, if4.reg_dst,
             if4.reg_write, if4.alu_src_a, if4.alu_src_b, if4.alu_op, if4.pc_src};
      n_cmp += 8;
      if (if16.state !== 4'(st)) begin n_err++;
        $display("FAIL state t=%0t got %0d exp %0d", $time, if16.state, st); end
      if (if4.state !== 4'(st)) begin n_err++;
        $display("FAIL state4 t=%0t got %0d exp %0d", $time, if4.state, st); end
      if (a16 !== e) begin n_err++;
        $display("FAIL strobes t=%0t st=%0d got %h exp %h", $time, st, a16, e); end
      if (a4 !== e) begin n_err++;
        $display("FAIL strobes4 t=%0t st=%0d got %h exp %h", $time, st, a4, e); end
      if (if16.instr_done !== m_done) begin n_err++;
        $display("FAIL instr_done t=%0t got %b exp %b", $time, if16.instr_done, m_done); end
      if (if16.illegal_op !== m_ill) begin n_err++;
        $display("FAIL illegal_op t=%0t got %b exp %b", $time, if16.illegal_op, m_ill); end
      if (if16.instr_count !== 16'(m_cnt)) begin n_err++;
        $display("FAIL cnt16 t=%0t got %0d exp %0d", $time, if16.instr_count, 16'(m_cnt)); end
      if (if4.instr_count !== 4'(m_cnt)) begin n_err++;
        $display("FAIL cnt4 t=%0t got %0d exp %0d", $time, if4.instr_count, 4'(m_cnt)); end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", name, act, exp);
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic z, input int fs,
                           input int ms, output int cyc);
    bit started;
    opcode = op; zero = z; mst = ms;
    if (fs > 0) begin mem_ready = 0; fst = fs - 1; end
    cyc = 0; started = 0;
    while (1) begin
      @(posedge clk); #2;
      cyc++;
      if (m_pos != 0) started = 1;
      if ((started && m_pos == 0) || cyc >= 60) break;
    end
    if (cyc >= 60) begin n_cmp++; n_err++; $display("FAIL timeout op=%b", op); end
  endtask

  initial begin
    int cyc, guard;
    rst_n = 0; opcode = 6'b000000; zero = 0; mem_ready = 1;
    @(posedge clk); #2; chk_en = 1;
    @(posedge clk); #2; rst_n = 1;
    check("reset_state", int'(if16.state), 0);
    check("reset_cnt", int'(if16.instr_count), 0);

    // reset mid-load, held 2 cycles while in MEMRD
    opcode = 6'b100011; mst = 50; guard = 0;
    while (m_pos != 3 && guard < 20) begin @(posedge clk); #2; guard++; end
    check("reach_memrd", m_pos, 3);
    rst_n = 0;
    @(negedge clk);
    check("rst_reg_write", int'(if16.reg_write), 0);
    check("rst_mem_write", int'(if16.mem_write), 0);
    check("rst_pc_write", int'(if16.pc_write), 0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1; mst = 0;
    @(negedge clk);
    check("post_rst_state", int'(if16.state), 0);
    check("post_rst_cnt", int'(if16.instr_count), 0);
    @(posedge clk); #2;  // state FETCH, next instruction starts here
    check("post_rst_decode", m_pos, 1);
    // that first FETCH already passed; let the reset-aborted fetch finish as rtype
    opcode = 6'b000000;
    guard = 0;
    while (m_pos != 0 && guard < 20) begin @(posedge clk); #2; guard++; end
    check("realign_cnt", m_cnt, 1);

    run_instr(6'b000000, 0, 0, 0, cyc); check("rtype_lat", cyc, 4);
    check("rtype_cnt", int'(if16.instr_count), 2);
    run_instr(6'b100011, 0, 0, 3, cyc); check("lw_stall_lat", cyc, 8);
    check("lw_cnt", int'(if16.instr_count), 3);
    run_instr(6'b101011, 0, 0, 0, cyc); check("sw_lat", cyc, 4);
    run_instr(6'b000100, 1, 0, 0, cyc); check("beq_lat", cyc, 3);
    check("sw_beq_cnt", int'(if16.instr_count), 5);
    run_instr(6'b111111, 0, 0, 0, cyc); check("illegal_lat", cyc, 2);
    check("illegal_cnt", int'(if16.instr_count), 5);
    run_instr(6'b001000, 0, 0, 0, cyc); check("addi_lat", cyc, 4);
    run_instr(6'b000000, 0, 2, 0, cyc); check("rtype_fstall_lat", cyc, 6);
    run_instr(6'b101011, 0, 0, 2, cyc); check("sw_stall_lat", cyc, 6);
    run_instr(6'b100101, 0, 1, 1, cyc); check("lhu_stall_lat", cyc, 7);

    // counter wrap on the 4-bit instance
    rst_n = 0; @(posedge clk); #2; rst_n = 1;
    for (int i = 0; i < 17; i++) begin
      run_instr(6'b000010, 0, 0, 0, cyc);
      check("j_lat", cyc, 3);
      if (i == 14) check("cnt4_15", int'(if4.instr_count), 15);
      if (i == 15) check("cnt4_wrap0", int'(if4.instr_count), 0);
      if (i == 16) check("cnt4_wrap1", int'(if4.instr_count), 1);
    end
    check("cnt16_17", int'(if16.instr_count), 17);

    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
